// File: rtl/pe_array_sequencer.sv
// Sequences one frame of column windows from a line buffer into a KxK PE array.
// It also tags every window, so each convolution result leaves with its row and column.
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   start, abort              - frame start pulse; abort of the frame in progress
//   img_width, img_height     - frame size W and H, sampled when start is taken
//   rd_req, rd_row, rd_col    - window request to the line buffer (top row, column)
//   rd_valid, col_data        - request accepted; K stacked pixels in the same cycle
//   arr_en, arr_data          - PE array enable and column data
//   arr_done                  - PE array result strobe, ARRAY_LATENCY after arr_en
//   out_valid, out_row/col    - a valid convolution result and its coordinates
//   busy, frame_done, cfg_err, seq_err - status
module pe_array_sequencer #(
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DIM_WIDTH     = 10,
  parameter int unsigned ARRAY_LATENCY = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              abort,
  input  logic [DIM_WIDTH-1:0]              img_width,
  input  logic [DIM_WIDTH-1:0]              img_height,
  output logic                              rd_req,
  output logic [DIM_WIDTH-1:0]              rd_row,
  output logic [DIM_WIDTH-1:0]              rd_col,
  input  logic                              rd_valid,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] col_data,
  output logic                              arr_en,
  output logic [DATA_WIDTH*KERNEL_SIZE-1:0] arr_data,
  input  logic                              arr_done,
  output logic                              out_valid,
  output logic [DIM_WIDTH-1:0]              out_row,
  output logic [DIM_WIDTH-1:0]              out_col,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              cfg_err,
  output logic                              seq_err
);

  localparam int unsigned          COL_WIDTH = DATA_WIDTH * KERNEL_SIZE;
  localparam logic [DIM_WIDTH-1:0] K_DIM     = DIM_WIDTH'(KERNEL_SIZE);
  localparam logic [DIM_WIDTH-1:0] KM1_DIM   = DIM_WIDTH'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {IDLE, CHECK, FEED, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                 en;
    logic [DIM_WIDTH-1:0] row;
    logic [DIM_WIDTH-1:0] col;
    logic                 ok;
  } tag_t;

  state_t               state_q, state_d;
  logic [DIM_WIDTH-1:0] w_q, w_d, h_q, h_d;
  logic [DIM_WIDTH-1:0] r_q, r_d, c_q, c_d;
  tag_t                 tag_q [ARRAY_LATENCY];
  tag_t                 tag_in, tag_exit;
  logic                 tag_any;
  logic                 kill;
  logic                 seq_err_q;

  // Abort only acts on a frame in progress.
  assign kill = abort && (state_q != IDLE);

  // State, frame size and window counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  // Next state, counter update and per-state strobes.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    r_d        = r_q;
    c_d        = c_q;
    rd_req     = 1'b0;
    arr_en     = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    cfg_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          w_d     = img_width;
          h_d     = img_height;
          state_d = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        r_d  = '0;
        c_d  = '0;
        if ((w_q < K_DIM) || (h_q < K_DIM)) begin
          cfg_err = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = FEED;
        end
      end
      FEED: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        if (rd_valid) begin
          arr_en = 1'b1;
          if (c_q == w_q - DIM_WIDTH'(1)) begin
            c_d = '0;
            r_d = r_q + DIM_WIDTH'(1);
            if (r_q == h_q - K_DIM) state_d = DRAIN;
          end else begin
            c_d = c_q + DIM_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!tag_any) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (kill) begin
      state_d    = IDLE;
      r_d        = '0;
      c_d        = '0;
      arr_en     = 1'b0;
      frame_done = 1'b0;
      cfg_err    = 1'b0;
    end
  end

  assign rd_row   = rd_req ? r_q : '0;
  assign rd_col   = rd_req ? c_q : '0;
  assign arr_data = arr_en ? col_data : COL_WIDTH'(0);

  // The tag entering the pipeline marks windows whose column completes a full kernel.
  always_comb begin
    tag_in.en  = arr_en;
    tag_in.row = r_q;
    tag_in.col = c_q;
    tag_in.ok  = (c_q >= KM1_DIM);
  end

  // The tag pipeline mirrors the PE array latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(ARRAY_LATENCY); i++) tag_q[i] <= '0;
    end else if (kill) begin
      for (int i = 0; i < int'(ARRAY_LATENCY); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < int'(ARRAY_LATENCY); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i < int'(ARRAY_LATENCY); i++) tag_any = tag_any | tag_q[i].en;
  end

  assign tag_exit  = tag_q[ARRAY_LATENCY-1];
  assign out_valid = arr_done && tag_exit.en && tag_exit.ok;
  assign out_row   = out_valid ? tag_exit.row : '0;
  assign out_col   = out_valid ? (tag_exit.col - KM1_DIM) : '0;

  // Sticky: the array strobe disagreed with the tag, until the next accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_err_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      seq_err_q <= 1'b0;
    end else if (arr_done != tag_exit.en) begin
      seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer: table of frames plus abort, sequence-error and reset cases.
module tb_pe_array_sequencer;

  localparam int K   = 3;
  localparam int DW  = 8;
  localparam int DIM = 10;
  localparam int LAT = 4;

  logic            clk, rstn, start, abort;
  logic [DIM-1:0]  img_width, img_height;
  logic            rd_req, rd_valid, arr_en, arr_done;
  logic [DIM-1:0]  rd_row, rd_col, out_row, out_col;
  logic [DW*K-1:0] col_data, arr_data;
  logic            out_valid, busy, frame_done, cfg_err, seq_err;

  pe_array_sequencer #(
    .KERNEL_SIZE(K), .DATA_WIDTH(DW), .DIM_WIDTH(DIM), .ARRAY_LATENCY(LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .img_width(img_width), .img_height(img_height),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rd_valid), .col_data(col_data),
    .arr_en(arr_en), .arr_data(arr_data), .arr_done(arr_done),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE array model: arr_done follows arr_en by LAT cycles; flushed on abort.
  logic [LAT-1:0] arr_pipe;
  logic           force_done;
  always @(posedge clk or negedge rstn) begin
    if (!rstn)      arr_pipe <= '0;
    else if (abort) arr_pipe <= '0;
    else            arr_pipe <= {arr_pipe[LAT-2:0], arr_en};
  end
  assign arr_done = arr_pipe[LAT-1] | force_done;

  logic [127:0] all_outs;
  assign all_outs = 128'({rd_req, rd_row, rd_col, arr_en, arr_data, out_valid, out_row,
                          out_col, busy, frame_done, cfg_err, seq_err});

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame starting in the current cycle; checks result coordinates in raster order.
  task automatic run_frame(input int w, input int h, input bit stall,
                           output int acc, output int outs, output int dones,
                           output int cfgs, output int viol);
    int  exp_r[$];
    int  exp_c[$];
    bit  fin;
    acc = 0; outs = 0; dones = 0; cfgs = 0; viol = 0; fin = 0;
    for (int r = 0; r <= h - K; r++)
      for (int c = 0; c <= w - K; c++) begin
        exp_r.push_back(r);
        exp_c.push_back(c);
      end
    img_width  = DIM'(w);
    img_height = DIM'(h);
    start      = 1'b1;
    rd_valid   = 1'b0;
    #3;
    step();
    start      = 1'b0;
    img_width  = DIM'($urandom);
    img_height = DIM'($urandom);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      rd_valid = stall ? cyc[0] : 1'b1;
      col_data = (DW*K)'($urandom);
      #3;
      if (rd_req && rd_valid) acc++;
      if (arr_en !== (rd_req && rd_valid)) viol++;
      if (arr_en && (arr_data !== col_data)) viol++;
      if (out_valid) begin
        if (outs < exp_r.size()) begin
          check("out_row", 128'(out_row), 128'(exp_r[outs]));
          check("out_col", 128'(out_col), 128'(exp_c[outs]));
        end
        outs++;
      end
      if (frame_done) dones++;
      if (cfg_err) cfgs++;
      if (frame_done || cfg_err) fin = 1;
      step();
    end
    rd_valid = 1'b0;
    check("frame_timeout", 128'(fin), 128'(1));
  endtask

  typedef struct {
    int w;
    int h;
    bit stall;
    int exp_acc;
    int exp_out;
    int exp_done;
    int exp_cfg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int acc, outs, dones, cfgs, viol;

    // Each frame reads (H-K+1)*W windows and yields (H-K+1)*(W-K+1) results.
    vecs[0] = '{w: 5, h: 4, stall: 0, exp_acc: 10, exp_out: 6, exp_done: 1, exp_cfg: 0};
    vecs[1] = '{w: 5, h: 4, stall: 1, exp_acc: 10, exp_out: 6, exp_done: 1, exp_cfg: 0};
    vecs[2] = '{w: 2, h: 8, stall: 0, exp_acc: 0,  exp_out: 0, exp_done: 0, exp_cfg: 1};
    vecs[3] = '{w: 3, h: 3, stall: 0, exp_acc: 3,  exp_out: 1, exp_done: 1, exp_cfg: 0};
    vecs[4] = '{w: 8, h: 2, stall: 0, exp_acc: 0,  exp_out: 0, exp_done: 0, exp_cfg: 1};
    vecs[5] = '{w: 4, h: 5, stall: 1, exp_acc: 12, exp_out: 6, exp_done: 1, exp_cfg: 0};
    vecs[6] = '{w: 3, h: 8, stall: 0, exp_acc: 18, exp_out: 6, exp_done: 1, exp_cfg: 0};

    // Reset with active-looking inputs: every output must be 0.
    rstn = 1'b0; start = 1'b1; abort = 1'b0; force_done = 1'b1; rd_valid = 1'b1;
    img_width = DIM'(5); img_height = DIM'(4); col_data = 24'hA5C3E1;
    #12;
    check("reset_outs", all_outs, 128'(0));
    step();
    rstn = 1'b1; start = 1'b0; force_done = 1'b0; rd_valid = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_frame(vecs[i].w, vecs[i].h, vecs[i].stall, acc, outs, dones, cfgs, viol);
      check($sformatf("v%0d_accepts", i), 128'(acc), 128'(vecs[i].exp_acc));
      check($sformatf("v%0d_results", i), 128'(outs), 128'(vecs[i].exp_out));
      check($sformatf("v%0d_frame_done", i), 128'(dones), 128'(vecs[i].exp_done));
      check($sformatf("v%0d_cfg_err", i), 128'(cfgs), 128'(vecs[i].exp_cfg));
      check($sformatf("v%0d_arr_en_data", i), 128'(viol), 128'(0));
      #3;
      check($sformatf("v%0d_idle_busy", i), 128'(busy), 128'(0));
      check($sformatf("v%0d_seq_err", i), 128'(seq_err), 128'(0));
      step();
    end

    // Abort in the cycle of the 7th request, with a start in that same cycle.
    img_width = DIM'(5); img_height = DIM'(4); start = 1'b1;
    #3; step();
    start = 1'b0; acc = 0;
    for (int cyc = 0; cyc < 100 && acc < 6; cyc++) begin
      rd_valid = 1'b1;
      #3;
      if (rd_req && rd_valid) acc++;
      step();
    end
    check("abort_pre_accepts", 128'(acc), 128'(6));
    rd_valid = 1'b1; abort = 1'b1; start = 1'b1; img_width = DIM'(3); img_height = DIM'(3);
    #3;
    check("abort_arr_en", 128'(arr_en), 128'(0));
    step();
    abort = 1'b0; start = 1'b0; rd_valid = 1'b0;
    #3;
    check("abort_idle", 128'({busy, rd_req}), 128'(0));
    dones = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      #3;
      if (frame_done) dones++;
    end
    check("abort_no_frame_done", 128'(dones), 128'(0));
    step();
    run_frame(3, 3, 0, acc, outs, dones, cfgs, viol);
    check("post_abort_results", 128'(outs), 128'(1));
    check("post_abort_done", 128'(dones), 128'(1));

    // Spurious array strobe while nothing is in flight: sticky until the next start.
    force_done = 1'b1;
    #3; step();
    force_done = 1'b0;
    #3;
    check("seq_err_set", 128'(seq_err), 128'(1));
    for (int cyc = 0; cyc < 5; cyc++) step();
    #3;
    check("seq_err_sticky", 128'(seq_err), 128'(1));
    step();
    start = 1'b1; img_width = DIM'(3); img_height = DIM'(3);
    #3; step();
    start = 1'b0;
    #3;
    check("seq_err_cleared", 128'(seq_err), 128'(0));
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // Reset in the middle of FEED: outputs drop without a clock edge.
    img_width = DIM'(5); img_height = DIM'(4); start = 1'b1;
    #3; step();
    start = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      rd_valid = 1'b1;
      step();
    end
    #1;
    check("mid_feed_busy", 128'({busy, rd_req}), 128'(3));
    rstn = 1'b0;
    #1;
    check("mid_reset_outs", all_outs, 128'(0));
    step();
    rd_valid = 1'b0;
    rstn = 1'b1;
    run_frame(5, 4, 0, acc, outs, dones, cfgs, viol);
    check("post_reset_accepts", 128'(acc), 128'(10));
    check("post_reset_results", 128'(outs), 128'(6));
    check("post_reset_done", 128'(dones), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
